// File: rtl/riscv_pkg.sv
// Shared integer register file types: data width, register address width and the writeback beat.
package riscv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_beat_t;

endpackage

// File: rtl/wb_skid_slot.sv
// One-entry writeback holding slot; ready depends only on slot state and the arbiter grant.
module wb_skid_slot
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     valid,
  output logic     ready,
  input  wb_beat_t din,
  input  logic     grant,
  output logic     full,
  output wb_beat_t slot
);

  logic     full_d;
  wb_beat_t slot_d;

  // A granted slot frees itself this edge, so it can take a new beat at the same time.
  assign ready = rst & (~full | grant);

  always_comb begin
    full_d = full;
    slot_d = slot;
    if (valid && ready) begin
      full_d = 1'b1;
      slot_d = din;
    end else if (grant) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      slot <= '0;
    end else begin
      full <= full_d;
      slot <= slot_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter driving the register file write port from an ALU (A) and an LSU/MUL (B) channel.
// Optional forwarding of the in-flight write is enabled with `define WB_BYPASS_EN.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] byp_a1,
  input  logic [REG_ADDR_W-1:0] byp_a2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [XLEN-1:0]       byp_data1,
  output logic [XLEN-1:0]       byp_data2
`endif
);

  localparam int unsigned STARVE_W = 4;

  logic                  full_a;
  logic                  full_b;
  wb_beat_t              slot_a;
  wb_beat_t              slot_b;
  logic                  grant_a;
  logic                  grant_b;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [STARVE_W-1:0]   starve_d;
  wb_beat_t              win;
  logic                  granted;
  logic                  we3_d;
  logic [REG_ADDR_W-1:0] a3_d;
  logic [XLEN-1:0]       wd3_d;

  wb_skid_slot u_slot_a (
    .clk   (clk),
    .rst   (rst),
    .valid (a_valid),
    .ready (a_ready),
    .din   (wb_beat_t'{rd: a_rd, data: a_data}),
    .grant (grant_a),
    .full  (full_a),
    .slot  (slot_a)
  );

  wb_skid_slot u_slot_b (
    .clk   (clk),
    .rst   (rst),
    .valid (b_valid),
    .ready (b_ready),
    .din   (wb_beat_t'{rd: b_rd, data: b_data}),
    .grant (grant_b),
    .full  (full_b),
    .slot  (slot_b)
  );

  // A has priority unless B has already lost STARVE_MAX times in a row.
  assign grant_b = full_b & (~full_a | (starve_cnt == STARVE_W'(STARVE_MAX)));
  assign grant_a = full_a & ~grant_b;

  always_comb begin
    starve_d = starve_cnt;
    win      = grant_b ? slot_b : slot_a;
    granted  = grant_a | grant_b;
    we3_d    = granted & (win.rd != REG_ZERO);
    a3_d     = A3;
    wd3_d    = WD3;
    if (!full_b || grant_b) begin
      starve_d = '0;
    end else if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
      starve_d = starve_cnt + STARVE_W'(1);
    end
    if (granted) begin
      a3_d  = win.rd;
      wd3_d = win.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      WE3        <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
    end else begin
      starve_cnt <= starve_d;
      WE3        <= we3_d;
      A3         <= a3_d;
      WD3        <= wd3_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write being committed this cycle to same-cycle readers.
  assign byp_hit1  = WE3 & (A3 == byp_a1) & (byp_a1 != REG_ZERO);
  assign byp_hit2  = WE3 & (A3 == byp_a2) & (byp_a2 != REG_ZERO);
  assign byp_data1 = byp_hit1 ? WD3 : '0;
  assign byp_data2 = byp_hit2 ? WD3 : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a queue-based writeback model.
module tb_regfile_wb_arbiter;
  import riscv_pkg::*;

  localparam int unsigned STARVE_MAX = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [4:0]      a_rd, b_rd;
  logic [63:0]     a_data, b_data;
  logic            WE3;
  logic [4:0]      A3;
  logic [63:0]     WD3;
`ifdef WB_BYPASS_EN
  logic [4:0]      byp_a1, byp_a2;
  logic            byp_hit1, byp_hit2;
  logic [63:0]     byp_data1, byp_data2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending beats per channel, consecutive B losses, and the expected write port.
  wb_beat_t    q_a[$];
  wb_beat_t    q_b[$];
  int unsigned m_lost;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [63:0] m_wd;
  int unsigned b_stall;
  logic        last_a_ready;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_rd    (a_rd),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_rd    (b_rd),
    .b_data  (b_data),
    .WE3     (WE3),
    .A3      (A3),
    .WD3     (WD3)
`ifdef WB_BYPASS_EN
    ,
    .byp_a1    (byp_a1),
    .byp_a2    (byp_a2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_grant_b();
    return (q_b.size() != 0) && ((q_a.size() == 0) || (m_lost >= STARVE_MAX));
  endfunction

  function automatic bit exp_ready(input bit ch_b);
    bit gb;
    bit ga;
    gb = model_grant_b();
    ga = (q_a.size() != 0) && !gb;
    return ch_b ? ((q_b.size() == 0) || gb) : ((q_a.size() == 0) || ga);
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    m_lost  = 0;
    m_we    = 1'b0;
    m_a3    = '0;
    m_wd    = '0;
    b_stall = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit       ga, gb, ra, rb;
    wb_beat_t w;
    gb = model_grant_b();
    ga = (q_a.size() != 0) && !gb;
    ra = exp_ready(1'b0);
    rb = exp_ready(1'b1);
    if (ga || gb) begin
      w    = gb ? q_b[0] : q_a[0];
      m_we = (w.rd != 5'd0);
      m_a3 = w.rd;
      m_wd = w.data;
    end else begin
      m_we = 1'b0;
    end
    if ((q_b.size() == 0) || gb) m_lost = 0;
    else if (m_lost < STARVE_MAX) m_lost++;
    if (ga) void'(q_a.pop_front());
    if (gb) void'(q_b.pop_front());
    if (a_valid && ra) q_a.push_back(wb_beat_t'{rd: a_rd, data: a_data});
    if (b_valid && rb) q_b.push_back(wb_beat_t'{rd: b_rd, data: b_data});
  endtask

  task automatic step(input logic va, input logic [4:0] rda, input logic [63:0] da,
                      input logic vb, input logic [4:0] rdb, input logic [63:0] db);
    @(negedge clk);
    chk("we3", 64'(WE3), 64'(m_we));
    chk("a3", 64'(A3), 64'(m_a3));
    chk("wd3", WD3, m_wd);
    chk("a_ready", 64'(a_ready), 64'(exp_ready(1'b0)));
    chk("b_ready", 64'(b_ready), 64'(exp_ready(1'b1)));
    last_a_ready = a_ready;
    if (!b_ready) b_stall++;
    else b_stall = 0;
    chk("b_starve_bound", 64'(b_stall > STARVE_MAX), 64'd0);
    a_valid = va; a_rd = rda; a_data = da;
    b_valid = vb; b_rd = rdb; b_data = db;
    model_edge();
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_valid = 1'($urandom); a_rd = 5'($urandom); a_data = {$urandom, $urandom};
      b_valid = 1'($urandom); b_rd = 5'($urandom); b_data = {$urandom, $urandom};
      chk("rst_we3", 64'(WE3), 64'd0);
      chk("rst_a3", 64'(A3), 64'd0);
      chk("rst_wd3", WD3, 64'd0);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_a_ready", 64'(a_ready), 64'd1);
    chk("rel_b_ready", 64'(b_ready), 64'd1);
  endtask

  initial begin
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
`ifdef WB_BYPASS_EN
    byp_a1 = '0; byp_a2 = '0;
`endif
    rst = 1'b0;
    model_reset();
    hold_reset(5);

    // Single A beat: write visible exactly one cycle after E+1.
    step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1;
    chk("single_we", 64'(WE3), 64'd1);
    chk("single_a3", 64'(A3), 64'd5);
    chk("single_wd3", WD3, 64'hDEAD_BEEF);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1;
    chk("single_we_drop", 64'(WE3), 64'd0);

    // x0 write: handshake completes, nothing reaches the register file.
    idle(2);
    step(1'b1, 5'd0, 64'd1, 1'b0, 5'd0, 64'd0);
    chk("x0_handshake", 64'(last_a_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      #1;
      chk("x0_we", 64'(WE3), 64'd0);
    end

    // Both channels streaming: writes follow A,A,A,B.
    idle(3);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 5'(1 + i % 15), {$urandom, $urandom},
           1'b1, 5'(16 + i % 16), {$urandom, $urandom});
      #1;
      if (i >= 1) begin
        chk("stream_we", 64'(WE3), 64'd1);
        chk("stream_chan_b", 64'(A3 >= 5'd16), 64'(((i - 1) % 4) == 3));
      end
    end

    // Random traffic, including x0 destinations and back-pressure.
    idle(4);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom), {$urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 5'($urandom), {$urandom, $urandom});
    end

    // Reset mid-operation while a write is in flight.
    idle(4);
    step(1'b1, 5'd3, 64'h33, 1'b1, 5'd20, 64'h44);
    step(1'b1, 5'd4, 64'h55, 1'b1, 5'd21, 64'h66);
    #1;
    chk("mid_we_before", 64'(WE3), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_we_async", 64'(WE3), 64'd0);
    chk("mid_a_ready", 64'(a_ready), 64'd0);
    hold_reset(3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      #1;
      chk("post_rst_no_stale", 64'(WE3), 64'd0);
    end

`ifdef WB_BYPASS_EN
    step(1'b1, 5'd7, 64'd42, 1'b0, 5'd0, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    byp_a1 = 5'd7;
    byp_a2 = 5'd0;
    #1;
    chk("byp_we", 64'(WE3), 64'd1);
    chk("byp_hit1", 64'(byp_hit1), 64'd1);
    chk("byp_data1", byp_data1, 64'd42);
    chk("byp_hit2", 64'(byp_hit2), 64'd0);
    chk("byp_data2", byp_data2, 64'd0);
    idle(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
